vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Upstream access controller for the single-port video/work RAM (`spram`): it owns that RAM's `address`/`data`/`we` inputs and `q` output. It multiplexes a CPU port and a video-scan read port onto the single port, with one access per clock and round-robin priority when both ports request. After reset it zero-fills the whole RAM, so the game always starts from a clean framebuffer.

## Interface
Parameters:
- `data_width`, 8, RAM word width
- `address_width`, 11, RAM address width; depth = 2**address_width

Ports:
- `clock`  in  1  system clock; all logic is on its rising edge
- `reset_n`  in  1  reset, synchronous and active-low
- `cpu_req`  in  1  CPU access request, level, held until `cpu_ack`
- `cpu_we`  in  1  1 = write, 0 = read; valid while `cpu_req`
- `cpu_addr`  in  address_width  CPU address
- `cpu_din`  in  data_width  CPU write data
- `cpu_ack`  out  1  one-cycle pulse: access complete
- `cpu_dout`  out  data_width  read data; on a write, the written data; valid with `cpu_ack`, held afterwards
- `vid_req`  in  1  video read request, level, held until `vid_valid`
- `vid_addr`  in  address_width  video read address
- `vid_valid`  out  1  one-cycle pulse: `vid_dout` valid
- `vid_dout`  out  data_width  video read data, held until the next `vid_valid`
- `ram_address`  out  address_width  to the RAM's `address`
- `ram_data`  out  data_width  to the RAM's `data`
- `ram_we`  out  1  to the RAM's `we`
- `ram_q`  in  data_width  from the RAM's `q`; registered, 1-cycle latency
- `busy`  out  1  high while the clear sweep runs

## Operation
- **Reset values** (edge with `reset_n`=0):
  - `ram_address`, `ram_data`, `ram_we`, `cpu_ack`, `cpu_dout`, `vid_valid`, `vid_dout` = 0
  - `busy` = 1; FSM = CLEAR; clear counter = 0
  - outstanding flags cleared; round-robin pointer = CPU
- **State CLEAR**:
  - Each cycle the block registers `ram_we`=1, `ram_data`=0 and `ram_address`=counter, then increments the counter.
  - After address 2**address_width-1 is issued, it goes to RUN and `busy` falls on the next edge.
  - Requests are ignored in CLEAR and stay pending; no acks are issued.
  - Reset asserted mid-clear restarts the sweep at address 0.
- **State RUN**: each cycle grants at most one *eligible* requester. A requester is eligible when its req is 1 and it has no access in flight.
  - Only one requester eligible: grant it.
  - Both eligible: grant the port the pointer names; the pointer then moves to the other port.
  - A single grant also moves the pointer to the other port.
  - Grant registers `ram_address`/`ram_data`/`ram_we`: `ram_we` = `cpu_we` for CPU and 0 for video; `ram_data` = `cpu_din`.
  - Grant also sets a 2-stage in-flight tag recording the owner.
  - No grant: `ram_we` = 0; address and data hold their values.
- **Completion**:
  - Two edges after the grant, the owner's dout is loaded from `ram_q` and its ack/valid pulses for one cycle.
  - The owner's in-flight flag clears on the same edge.
  - The requester may drop req in the ack cycle; if req is still high in the ack cycle, that counts as a new request.
- **Widths**: the clear counter is address_width+1 bits; its MSB marks completion. No other arithmetic.

## Timing
- Grant edge E0 (req sampled 1): `ram_*` valid after E0; RAM samples at E1; `ram_q` valid after E1; ack/valid and dout are registered at E2.
  - Request-to-ack latency is 2 cycles when uncontended and at most 3 when contended.
- Throughput is one access per cycle overall. Each port gets at most one access per 3 cycles, because one access is in flight per port.
- Simultaneous CPU and video completions are impossible: grants are one per cycle, so completions are one per cycle.
- A write completes with `cpu_dout` = written data, because the RAM returns the write data on `q`.
- `busy` falls exactly 2**address_width cycles after the first edge with `reset_n`=1.

## Test plan
- **Clear sweep**: address_width=11, release reset → `ram_we`=1 for exactly 2048 consecutive cycles with addresses 0..2047 and data 0. Then `busy`=0, and reading 0x000, 0x3FF and 0x7FF returns 0x00.
- **CPU write/read**: write 0xA5 to 0x123; `cpu_ack` 2 cycles after `cpu_req` with `cpu_dout`=0xA5. Then read 0x123 → `cpu_ack` at +2 with `cpu_dout`=0xA5.
- **Video read**: preload 0x3C at 0x010; `vid_req` at 0x010 → `vid_valid` at +2 with `vid_dout`=0x3C; no `cpu_ack`.
- **Contention**: both req rise in the same cycle, with the pointer at CPU after reset+clear → CPU granted at E0 and video at E1. `cpu_ack` at E2, `vid_valid` at E3. Each requester gets exactly one ack, with no double grant while its req stays high.
- **Request during clear**: `cpu_req` write 0x77 to 0x005 asserted 10 cycles after reset release → no ack until `busy`=0. The write lands after the sweep, and a subsequent read returns 0x77, not 0.
- **Reset mid-clear**: pulse `reset_n` low for 1 cycle at sweep address 500 → all outputs return to reset values; the sweep restarts at 0 and `busy` falls 2048 cycles after reset release.

Source files
------------

// File: rtl/vram_arbiter.sv
// Single-port video RAM access controller: zero-fills the RAM after reset, then
// arbitrates CPU and video-scan accesses round-robin, one access per clock.
module vram_arbiter #(
   parameter int unsigned data_width    = 8,
   parameter int unsigned address_width = 11
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     cpu_req,
   input  logic                     cpu_we,
   input  logic [address_width-1:0] cpu_addr,
   input  logic [data_width-1:0]    cpu_din,
   output logic                     cpu_ack,
   output logic [data_width-1:0]    cpu_dout,
   input  logic                     vid_req,
   input  logic [address_width-1:0] vid_addr,
   output logic                     vid_valid,
   output logic [data_width-1:0]    vid_dout,
   output logic [address_width-1:0] ram_address,
   output logic [data_width-1:0]    ram_data,
   output logic                     ram_we,
   input  logic [data_width-1:0]    ram_q,
   output logic                     busy
);

   typedef enum logic [0:0] {StClear, StRun} state_t;

   localparam logic [address_width:0] cnt_one = 1;

   state_t                   state_q;
   logic [address_width:0]   clr_cnt_q;
   logic                     cpu_g1_q, cpu_g2_q;
   logic                     vid_g1_q, vid_g2_q;
   logic                     rr_vid_q;
   logic                     cpu_elig, vid_elig;
   logic                     grant_cpu, grant_vid;

   // A port with an access still in the two-stage pipeline cannot be granted again.
   always_comb begin
      cpu_elig  = cpu_req & ~(cpu_g1_q | cpu_g2_q);
      vid_elig  = vid_req & ~(vid_g1_q | vid_g2_q);
      grant_cpu = (state_q == StRun) & cpu_elig & (~vid_elig | ~rr_vid_q);
      grant_vid = (state_q == StRun) & vid_elig & ~grant_cpu;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= StClear;
         clr_cnt_q   <= '0;
         cpu_g1_q    <= 1'b0;
         cpu_g2_q    <= 1'b0;
         vid_g1_q    <= 1'b0;
         vid_g2_q    <= 1'b0;
         rr_vid_q    <= 1'b0;
         ram_address <= '0;
         ram_data    <= '0;
         ram_we      <= 1'b0;
         cpu_ack     <= 1'b0;
         cpu_dout    <= '0;
         vid_valid   <= 1'b0;
         vid_dout    <= '0;
         busy        <= 1'b1;
      end else begin
         cpu_g1_q  <= grant_cpu;
         vid_g1_q  <= grant_vid;
         cpu_g2_q  <= cpu_g1_q;
         vid_g2_q  <= vid_g1_q;
         cpu_ack   <= cpu_g2_q;
         vid_valid <= vid_g2_q;
         if (cpu_g2_q) cpu_dout <= ram_q;
         if (vid_g2_q) vid_dout <= ram_q;

         unique case (state_q)
            StClear: begin
               busy <= 1'b1;
               // Counter MSB set means the last address has already been issued.
               if (clr_cnt_q[address_width]) begin
                  state_q <= StRun;
                  busy    <= 1'b0;
                  ram_we  <= 1'b0;
               end else begin
                  ram_we      <= 1'b1;
                  ram_data    <= '0;
                  ram_address <= clr_cnt_q[address_width-1:0];
                  clr_cnt_q   <= clr_cnt_q + cnt_one;
               end
            end
            StRun: begin
               busy   <= 1'b0;
               ram_we <= 1'b0;
               if (grant_cpu) begin
                  ram_address <= cpu_addr;
                  ram_data    <= cpu_din;
                  ram_we      <= cpu_we;
                  rr_vid_q    <= 1'b1;
               end else if (grant_vid) begin
                  ram_address <= vid_addr;
                  ram_data    <= cpu_din;
                  rr_vid_q    <= 1'b0;
               end
            end
            default: state_q <= StClear;
         endcase
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural write-through single-port RAM.
module tb_vram_arbiter;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        cpu_req, cpu_we, cpu_ack;
   logic [10:0] cpu_addr;
   logic [7:0]  cpu_din, cpu_dout;
   logic        vid_req, vid_valid;
   logic [10:0] vid_addr;
   logic [7:0]  vid_dout;
   logic [10:0] ram_address;
   logic [7:0]  ram_data;
   logic        ram_we, busy;
   logic [7:0]  ram_q = 8'hFF;
   logic [7:0]  mem [0:2047] = '{default: 8'hFF};

   int n_vec  = 0;
   int n_miss = 0;
   int cpu_acks = 0;
   int vid_acks = 0;

   typedef struct {
      logic        is_vid;
      logic        we;
      logic [10:0] addr;
      logic [7:0]  din;
      logic [7:0]  exp_d;
   } vec_t;

   vec_t tbl [11];

   vram_arbiter #(.data_width(8), .address_width(11)) dut (
      .clock(clock), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_dout(vid_dout),
      .ram_address(ram_address), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q),
      .busy(busy)
   );

   always #5 clock = ~clock;

   // RAM returns the write data on q during a write.
   always @(posedge clock) begin
      if (ram_we) begin
         mem[ram_address] <= ram_data;
         ram_q            <= ram_data;
      end else begin
         ram_q <= mem[ram_address];
      end
   end

   always @(posedge clock) begin
      if (cpu_ack)   cpu_acks <= cpu_acks + 1;
      if (vid_valid) vid_acks <= vid_acks + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset();
      check("rst_ram_we", int'(ram_we), 0);
      check("rst_ram_address", int'(ram_address), 0);
      check("rst_ram_data", int'(ram_data), 0);
      check("rst_cpu_ack", int'(cpu_ack), 0);
      check("rst_cpu_dout", int'(cpu_dout), 0);
      check("rst_vid_valid", int'(vid_valid), 0);
      check("rst_vid_dout", int'(vid_dout), 0);
      check("rst_busy", int'(busy), 1);
   endtask

   // Called right after reset release; optionally raises a CPU write mid-sweep.
   task automatic sweep(input int req_at);
      int writes, errs, fall, early;
      writes = 0; errs = 0; fall = 0; early = 0;
      for (int c = 1; c <= 3000 && fall == 0; c++) begin
         @(negedge clock);
         if (ram_we) begin
            if (ram_address != writes[10:0] || ram_data != 8'h00) errs++;
            writes++;
         end
         if (cpu_ack || vid_valid) early++;
         if (!busy) fall = c;
         if (c == req_at) begin
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h005; cpu_din = 8'h77;
         end
      end
      check("sweep_writes", writes, 2048);
      check("sweep_order", errs, 0);
      check("busy_fall_cycle", fall, 2049);
      check("no_ack_in_clear", early, 0);
   endtask

   task automatic run_vec(input vec_t v);
      int n, c0, v0;
      logic [7:0] d;
      c0 = cpu_acks; v0 = vid_acks; n = 0; d = 8'h00;
      if (v.is_vid) begin
         vid_req = 1'b1; vid_addr = v.addr;
      end else begin
         cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_din = v.din;
      end
      for (int i = 1; i <= 10; i++) begin
         @(negedge clock);
         if (n == 0 && (v.is_vid ? vid_valid : cpu_ack)) begin
            n = i;
            d = v.is_vid ? vid_dout : cpu_dout;
            cpu_req = 1'b0; vid_req = 1'b0;
         end
      end
      cpu_req = 1'b0; vid_req = 1'b0;
      repeat (3) @(negedge clock);
      check(v.is_vid ? "vid_latency" : "cpu_latency", n - 1, 2);
      check(v.is_vid ? "vid_dout" : "cpu_dout", int'(d), int'(v.exp_d));
      check("own_ack_count", v.is_vid ? vid_acks - v0 : cpu_acks - c0, 1);
      check("other_ack_count", v.is_vid ? cpu_acks - c0 : vid_acks - v0, 0);
   endtask

   task automatic contend(input logic [10:0] ca, input logic cw, input logic [7:0] cd,
                          input logic [10:0] va, input logic [7:0] ec, input logic [7:0] ev,
                          input int ecl, input int evl);
      int cn, vn, c0, v0;
      c0 = cpu_acks; v0 = vid_acks; cn = 0; vn = 0;
      cpu_req = 1'b1; cpu_we = cw; cpu_addr = ca; cpu_din = cd;
      vid_req = 1'b1; vid_addr = va;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clock);
         if (cpu_ack && cn == 0) begin
            cn = i; cpu_req = 1'b0;
            check("cont_cpu_dout", int'(cpu_dout), int'(ec));
         end
         if (vid_valid && vn == 0) begin
            vn = i; vid_req = 1'b0;
            check("cont_vid_dout", int'(vid_dout), int'(ev));
         end
      end
      cpu_req = 1'b0; vid_req = 1'b0;
      repeat (3) @(negedge clock);
      check("cont_cpu_latency", cn - 1, ecl);
      check("cont_vid_latency", vn - 1, evl);
      check("cont_cpu_acks", cpu_acks - c0, 1);
      check("cont_vid_acks", vid_acks - v0, 1);
   endtask

   initial begin
      int   n, found;
      vec_t last;
      reset_n = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
      vid_req = 1'b0; vid_addr = '0;

      tbl[0]  = '{1'b0, 1'b0, 11'h000, 8'h00, 8'h00};
      tbl[1]  = '{1'b0, 1'b0, 11'h3FF, 8'h00, 8'h00};
      tbl[2]  = '{1'b1, 1'b0, 11'h7FF, 8'h00, 8'h00};
      tbl[3]  = '{1'b0, 1'b0, 11'h005, 8'h00, 8'h77};
      tbl[4]  = '{1'b0, 1'b1, 11'h123, 8'hA5, 8'hA5};
      tbl[5]  = '{1'b0, 1'b0, 11'h123, 8'h00, 8'hA5};
      tbl[6]  = '{1'b0, 1'b1, 11'h010, 8'h3C, 8'h3C};
      tbl[7]  = '{1'b1, 1'b0, 11'h010, 8'h00, 8'h3C};
      tbl[8]  = '{1'b0, 1'b1, 11'h7FF, 8'h5A, 8'h5A};
      tbl[9]  = '{1'b1, 1'b0, 11'h7FF, 8'h00, 8'h5A};
      tbl[10] = '{1'b0, 1'b0, 11'h7FF, 8'h00, 8'h5A};

      repeat (3) @(negedge clock);
      check_reset();
      reset_n = 1'b1;
      sweep(10);

      // Sweep-time write: grant on the first RUN edge, ack two edges later.
      n = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clock);
         if (cpu_ack && n == 0) begin
            n = i;
            check("pending_dout", int'(cpu_dout), 8'h77);
            cpu_req = 1'b0;
         end
      end
      cpu_req = 1'b0;
      check("pending_ack_cycle", n, 3);

      for (int i = 0; i < 11; i++) run_vec(tbl[i]);

      // Last table access was CPU, so video wins the tie.
      contend(11'h123, 1'b0, 8'h00, 11'h010, 8'hA5, 8'h3C, 3, 2);

      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      found = 0;
      for (int i = 1; i <= 1000 && found == 0; i++) begin
         @(negedge clock);
         if (ram_we && ram_address == 11'd500) found = 1;
      end
      check("reached_addr_500", found, 1);
      reset_n = 1'b0;
      @(negedge clock);
      check_reset();
      reset_n = 1'b1;
      sweep(-1);

      // Pointer back at CPU: CPU write lands first, video then reads it.
      contend(11'h020, 1'b1, 8'h66, 11'h020, 8'h66, 8'h66, 2, 3);

      last = '{1'b0, 1'b0, 11'h123, 8'h00, 8'h00};
      run_vec(last);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
